// File: rtl/ripple_borrow_subtractor_seq.sv
// ============================================================================
//  Module      : ripple_borrow_subtractor_seq
//  Description : Multi-cycle ripple-borrow subtractor D = X - Y - Bi, STEP bits
//                per clock with valid/ready handshakes on both sides.
//                Optional signed-overflow flag: define RBS_OVERFLOW_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ripple_borrow_subtractor_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             V
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_d;
    logic             r_b;
    logic             r_bo;
    logic [CW-1:0]    r_cnt;

    logic [STEP-1:0]  w_xc;
    logic [STEP-1:0]  w_yc;
    logic [STEP-1:0]  w_dc;
    logic             w_b;
    logic             w_bc;
    logic [WIDTH-1:0] w_d_next;
    logic             w_last;

    assign w_last    = (r_cnt == c_LAST);
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign D         = r_d;
    assign Bo        = r_bo;

    // Select the active chunk and splice its difference back into D
    always_comb begin
        w_xc     = '0;
        w_yc     = '0;
        w_d_next = r_d;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_xc                     = r_x[k*STEP +: STEP];
                w_yc                     = r_y[k*STEP +: STEP];
                w_d_next[k*STEP +: STEP] = w_dc;
            end
        end
    end

    always_comb begin
        w_b  = r_b;
        w_dc = '0;
        for (int i = 0; i < STEP; i++) begin
            w_dc[i] = w_xc[i] ^ w_yc[i] ^ w_b;
            w_b     = (~w_xc[i] & w_yc[i]) | (~(w_xc[i] ^ w_yc[i]) & w_b);
        end
        w_bc = w_b;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
            S_BUSY:  if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_d   <= '0;
            r_b   <= 1'b0;
            r_bo  <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x   <= X;
                        r_y   <= Y;
                        r_b   <= Bi;
                        r_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_d   <= w_d_next;
                    r_b   <= w_bc;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_bo <= w_bc;
                end
                default: ;
            endcase
        end
    end

`ifdef RBS_OVERFLOW_EN
    logic r_v;

    // The MSB chunk is the last one, so its fresh difference bit is the result sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
        end else if (r_state == S_BUSY && w_last) begin
            r_v <= (r_x[WIDTH-1] ^ r_y[WIDTH-1]) & (w_dc[STEP-1] ^ r_x[WIDTH-1]);
        end
    end

    assign V = r_v;
`else
    assign V = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ripple_borrow_subtractor_seq.sv
// ============================================================================
//  Module      : tb_ripple_borrow_subtractor_seq
//  Description : Self-checking bench for ripple_borrow_subtractor_seq against
//                a plain-arithmetic reference of X - Y - Bi.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ripple_borrow_subtractor_seq;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int N     = WIDTH / STEP;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] X = '0;
    logic [WIDTH-1:0] Y = '0;
    logic             Bi = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             V;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ripple_borrow_subtractor_seq #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .Bi        (Bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bo        (Bo),
        .V         (V)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {V, Bo, D} from unsigned arithmetic one bit wider than the operands
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic bi);
        logic [WIDTH:0] full;
        logic           v;
        full = {1'b0, x} - {1'b0, y} - (WIDTH+1)'(bi);
        v    = 1'b0;
`ifdef RBS_OVERFLOW_EN
        v = (x[WIDTH-1] ^ y[WIDTH-1]) & (full[WIDTH-1] ^ x[WIDTH-1]);
`endif
        return {v, full};
    endfunction

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic bi);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        X = x; Y = y; Bi = bi; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X = $urandom; Y = $urandom; Bi = 1'($urandom);
    endtask

    task automatic collect(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic bi, input int stall, input bit pulse);
        logic [WIDTH+1:0] exp;
        exp = model(x, y, bi);
        for (int i = 1; i <= N; i++) begin
            if (pulse && i == 3) begin
                in_valid = 1'b1; X = ~x; Y = $urandom; Bi = ~bi;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (i == N - 1) check("out_valid_early", {31'd0, out_valid}, 32'd0);
        end
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("D", D, exp[WIDTH-1:0]);
        check("Bo", {31'd0, Bo}, {31'd0, exp[WIDTH]});
        check("V", {31'd0, V}, {31'd0, exp[WIDTH+1]});
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_D", D, exp[WIDTH-1:0]);
            check("stall_Bo", {31'd0, Bo}, {31'd0, exp[WIDTH]});
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
        check("D_hold", D, exp[WIDTH-1:0]);
    endtask

    task automatic op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic bi, input int stall, input bit pulse);
        send(x, y, bi);
        collect(x, y, bi, stall, pulse);
    endtask

    initial begin
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_D", D, 32'd0);
        check("rst_Bo", {31'd0, Bo}, 32'd0);
        check("rst_V", {31'd0, V}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op(32'd5, 32'd3, 1'b0, 0, 1'b0);
        op(32'd0, 32'd1, 1'b0, 0, 1'b0);
        op(32'h12345678, 32'h12345678, 1'b1, 0, 1'b0);
        op(32'h80000000, 32'd1, 1'b0, 0, 1'b0);
        op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
        op(32'hDEADBEEF, 32'h01234567, 1'b1, 5, 1'b1);

        // Abort mid-computation with operands that leave nonzero partial D
        send(32'hFFFFFFFF, 32'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_D", D, 32'd0);
        check("abort_Bo", {31'd0, Bo}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        op(32'd9, 32'd4, 1'b0, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            logic [WIDTH-1:0] rx;
            logic [WIDTH-1:0] ry;
            logic             rb;
            rx = $urandom;
            ry = (r % 4 == 0) ? rx : WIDTH'($urandom);
            rb = 1'($urandom);
            op(rx, ry, rb, int'($urandom_range(0, 3)), 1'(r % 5 == 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
